// File: rtl/mvu_accum.sv
// mvu_accum: per-lane saturating accumulation of reduction-tree beats into a 2-entry result FIFO
module mvu_accum #(
    parameter int REDW  = 32,
    parameter int L     = 3,
    parameter int SIZEW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SIZEW-1:0]  cmd_size,
    input  logic [L*REDW-1:0] din,
    input  logic              din_valid,
    output logic [L*REDW-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              err_orphan,
    output logic              err_ovf
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t state_q, state_d;
    logic [SIZEW-1:0] rem_q, rem_d, rem_eff;
    logic first_q, first_d, first_eff;
    logic [L*REDW-1:0] acc_q, acc_d, acc_new, slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0] cnt_q, cnt_d;
    logic orphan_q, orphan_d, ovf_q, ovf_d;
    logic accept, beat, last, pop, full;

    function automatic logic [REDW-1:0] sat_add(input logic [REDW-1:0] a, input logic [REDW-1:0] b);
        logic [REDW:0] s;
        s = {a[REDW-1], a} + {b[REDW-1], b};
        return (s[REDW] == s[REDW-1]) ? s[REDW-1:0] : {s[REDW], {(REDW-1){~s[REDW]}}};
    endfunction

    for (genvar i = 0; i < L; i++) begin : g_lane
        assign acc_new[i*REDW +: REDW] = first_eff ? din[i*REDW +: REDW]
                                                   : sat_add(acc_q[i*REDW +: REDW], din[i*REDW +: REDW]);
    end

    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q == ACC;
    assign dout       = slot0_q;
    assign dout_valid = cnt_q != 2'd0;
    assign err_orphan = orphan_q;
    assign err_ovf    = ovf_q;

    always_comb begin
        accept    = cmd_ready && cmd_valid;
        beat      = din_valid && (busy || accept);
        rem_eff   = busy ? rem_q : (cmd_size == '0 ? SIZEW'(1) : cmd_size);
        first_eff = busy ? first_q : 1'b1;
        last      = beat && rem_eff == SIZEW'(1);
        pop       = dout_valid && dout_ready;
        full      = cnt_q == 2'd2;
        state_d   = last ? IDLE : (accept ? ACC : state_q);
        rem_d     = beat ? rem_eff - SIZEW'(1) : (accept ? rem_eff : rem_q);
        first_d   = beat ? 1'b0 : (accept ? 1'b1 : first_q);
        acc_d     = beat ? acc_new : acc_q;
        orphan_d  = orphan_q | (din_valid && !busy && !accept);
        ovf_d     = ovf_q | (last && full && !pop);
        // pop shifts the head out first, so a same-cycle push lands behind the survivor
        slot0_d   = pop ? slot1_q : slot0_q;
        slot1_d   = slot1_q;
        cnt_d     = cnt_q - {1'b0, pop};
        if (last && !(full && !pop)) begin
            slot0_d = (cnt_d == 2'd0) ? acc_new : slot0_d;
            slot1_d = (cnt_d == 2'd0) ? slot1_q : acc_new;
            cnt_d   = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            first_q  <= 1'b1;
            acc_q    <= '0;
            slot0_q  <= '0;
            slot1_q  <= '0;
            cnt_q    <= 2'd0;
            orphan_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mvu_accum.sv
// tb_mvu_accum: per-cycle directed vectors with hand-computed expected outputs for mvu_accum
module tb_mvu_accum;
    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, din_valid, dout_valid, dout_ready, busy, err_orphan, err_ovf;
    logic [8:0]  cmd_size;
    logic [95:0] din, dout;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mvu_accum #(.REDW(32), .L(3), .SIZEW(9)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size),
        .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .err_orphan(err_orphan), .err_ovf(err_ovf)
    );

    typedef struct {
        bit rst; bit cv; bit [8:0] sz; bit dv; int d0; int d1; int d2; bit rdy;
        bit e_cr; bit e_busy; bit e_dv; bit chk; int o0; int o1; int o2; bit e_orph; bit e_ovf;
    } vec_t;

    function automatic vec_t mk(bit rst, bit cv, bit [8:0] sz, bit dv, int d0, int d1, int d2, bit rdy,
                                bit e_cr, bit e_busy, bit e_dv, bit chk, int o0, int o1, int o2, bit e_orph, bit e_ovf);
        vec_t x;
        x.rst = rst; x.cv = cv; x.sz = sz; x.dv = dv; x.d0 = d0; x.d1 = d1; x.d2 = d2; x.rdy = rdy;
        x.e_cr = e_cr; x.e_busy = e_busy; x.e_dv = e_dv; x.chk = chk;
        x.o0 = o0; x.o1 = o1; x.o2 = o2; x.e_orph = e_orph; x.e_ovf = e_ovf;
        return x;
    endfunction

    task automatic apply(input string name, input vec_t x);
        logic [95:0] exp_d;
        bit bad;
        reset = x.rst; cmd_valid = x.cv; cmd_size = x.sz; din_valid = x.dv;
        din = {x.d2, x.d1, x.d0}; dout_ready = x.rdy;
        @(posedge clk);
        #1;
        exp_d = {x.o2, x.o1, x.o0};
        bad = cmd_ready !== x.e_cr || busy !== x.e_busy || dout_valid !== x.e_dv ||
              err_orphan !== x.e_orph || err_ovf !== x.e_ovf || (x.chk && dout !== exp_d);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got cr=%b busy=%b dv=%b dout=%h orph=%b ovf=%b, want cr=%b busy=%b dv=%b dout=%h(chk=%b) orph=%b ovf=%b",
                     name, cmd_ready, busy, dout_valid, dout, err_orphan, err_ovf,
                     x.e_cr, x.e_busy, x.e_dv, exp_d, x.chk, x.e_orph, x.e_ovf);
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_size = '0; din_valid = 1'b0; din = '0; dout_ready = 1'b1;
        //               rst cv sz dv  d0 d1 d2  rdy  cr bsy dv chk o0 o1 o2  orph ovf
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 1,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4, 1,  1, 2, 3,  1,   0, 1, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 3,  1,   0, 1, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 3,  1,   0, 1, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 3,  1,   1, 0, 1, 1,  4, 8, 12, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 1, -5, 0, 7,  1,   1, 0, 1, 1, -5, 0, 7,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 2, 1, 32'h7FFFFFF0, 32'h80000001, -1, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h20, -4, 1, 1,  1, 0, 1, 1, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 10, 10, 10, 0,  1, 0, 1, 1, 10, 10, 10, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 20, 20, 20, 0,  1, 0, 1, 1, 10, 10, 10, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 30, 30, 30, 0,  1, 0, 1, 1, 10, 10, 10, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 1, 1, 20, 20, 20, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 1));
        tbl.push_back(mk(0, 0, 0, 1,  5, 5, 5,  1,   1, 0, 0, 0,  0, 0, 0,  1, 1));
        tbl.push_back(mk(0, 1, 2, 1,  3, 3, 3,  1,   0, 1, 0, 0,  0, 0, 0,  1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  4, 4, 4,  1,   1, 0, 1, 1,  7, 7, 7,  1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  1, 1));
        tbl.push_back(mk(0, 1, 5, 1,  1, 1, 1,  1,   0, 1, 0, 0,  0, 0, 0,  1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 1,  1,   0, 1, 0, 0,  0, 0, 0,  1, 1));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 1,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1, 1,  9, 9, 9,  1,   1, 0, 1, 1,  9, 9, 9,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 2, 1,  1, 1, 1,  1,   0, 1, 0, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 7, 1,  2, 2, 2,  1,   1, 0, 1, 1,  3, 3, 3,  0, 0));
        tbl.push_back(mk(0, 1, 1, 1,  5, 6, 7,  1,   1, 0, 1, 1,  5, 6, 7,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  1,   1, 0, 0, 0,  0, 0, 0,  0, 0));
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // saturation happens per addition, and idle cycles inside ACC do not disturb the sum
        apply("sat_a", mk(0, 1, 3, 1, 32'h7FFFFFF0, 32'h80000010, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        apply("sat_gap", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        apply("sat_b", mk(0, 0, 0, 1, 32'h20, -32'h20, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        apply("sat_c", mk(0, 0, 0, 1, -32'h10, 32'h10, 5, 1, 1, 0, 1, 1, 32'h7FFFFFEF, 32'h80000010, 10, 0, 0));
        apply("sat_end", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
